buzzer_arbiter: RTL and testbench

//   Shares one PWM tone generator (period-count driven beeper) between NREQ note sources: music player, key-click, alarm.

---
 rtl/buzzer_pkg.sv | 54 +++++
 rtl/ms_tick_gen.sv | 39 +++
 rtl/buzzer_arbiter.sv | 174 +++++++++++++++++
 tb/tb_buzzer_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// buzzer_pkg
//   Shared definitions for the buzzer arbiter:
//   - state_t: arbiter FSM states.
//   - Note period constants, in 50 MHz clk cycles per tone period (17 bits).
//     Jianpu naming: low D5..D7 = G4..B4, mid M1..M7 = C5..B5, high H1..H7 =
//     C6..B6, HH1/HH2 = C7/D7. A trailing S is a sharp. S alone is a rest.
//   - TICK_DIV_50M: clk cycles per millisecond at 50 MHz.
package buzzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int unsigned TICK_DIV_50M = 50000;

    // Rest: period 0 keeps the tone generator silent for the note's duration.
    localparam int unsigned S    = 0;

    localparam int unsigned D5   = 127551;
    localparam int unsigned D6   = 113636;
    localparam int unsigned D7   = 101239;

    localparam int unsigned M1   = 95557;
    localparam int unsigned M1S  = 90193;
    localparam int unsigned M2   = 85131;
    localparam int unsigned M2S  = 80354;
    localparam int unsigned M3   = 75843;
    localparam int unsigned M4   = 71586;
    localparam int unsigned M4S  = 67568;
    localparam int unsigned M5   = 63776;
    localparam int unsigned M5S  = 60196;
    localparam int unsigned M6   = 56818;
    localparam int unsigned M6S  = 53629;
    localparam int unsigned M7   = 50619;

    localparam int unsigned H1   = 47778;
    localparam int unsigned H1S  = 45097;
    localparam int unsigned H2   = 42566;
    localparam int unsigned H2S  = 40177;
    localparam int unsigned H3   = 37922;
    localparam int unsigned H4   = 35793;
    localparam int unsigned H4S  = 33784;
    localparam int unsigned H5   = 31888;
    localparam int unsigned H5S  = 30098;
    localparam int unsigned H6   = 28409;
    localparam int unsigned H6S  = 26815;
    localparam int unsigned H7   = 25310;

    localparam int unsigned HH1  = 23889;
    localparam int unsigned HH2  = 21283;

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen
//   Restartable millisecond prescaler. The counter is forced to 0 by restart,
//   so the first tick arrives exactly TICK_DIV cycles after the restart edge.
// Ports
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   restart  in   zero the prescaler on the next edge
//   tick     out  1-cycle pulse every TICK_DIV cycles after restart
module ms_tick_gen
    import buzzer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_50M
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter
//   Shares one period-driven tone generator between NREQ note sources.
//   Fixed priority (index 0 highest), no preemption. Each accepted note plays
//   for dur ms, then a silent GAP_MS gap follows before the next grant.
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   stop         in   abort current note/gap; blocks grants while high
//   req_valid    in   [NREQ]     note offered by source i
//   req_period   in   [NREQ*PW]  source i period (0 = rest)
//   req_dur      in   [NREQ*DW]  source i duration in ms
//   req_ready    out  [NREQ]     source i accepted this cycle (combinational)
//   done         out  [NREQ]     1-cycle pulse when source i's note finishes
//   tone_period  out  [PW]       period to the tone generator
//   tone_en      out  tone generator enable
//   gnt_id       out  [2]        current owner, valid while busy
//   busy         out  state is not IDLE
module buzzer_arbiter
    import buzzer_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int PW       = 17,
    parameter int DW       = 8,
    parameter int TICK_DIV = TICK_DIV_50M,
    parameter int GAP_MS   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stop,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*PW-1:0] req_period,
    input  logic [NREQ*DW-1:0] req_dur,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   done,
    output logic [PW-1:0]     tone_period,
    output logic              tone_en,
    output logic [1:0]        gnt_id,
    output logic              busy
);

    localparam logic [DW-1:0] GAP_LEN = DW'(GAP_MS);

    state_t          state, state_n;
    logic [DW-1:0]   ms_left, ms_left_n;
    logic [PW-1:0]   period_n;
    logic [1:0]      gnt_n;
    logic [NREQ-1:0] done_n;
    logic            tone_en_n;

    logic            any_valid;
    logic [1:0]      sel;
    logic            grant_ok;
    logic [PW-1:0]   sel_period;
    logic [DW-1:0]   sel_dur;
    logic            restart;
    logic            tick;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    // Priority select: scanning downward leaves the lowest valid index.
    always_comb begin
        any_valid = 1'b0;
        sel       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_valid = 1'b1;
                sel       = 2'(i);
            end
        end
    end

    assign grant_ok   = any_valid && (state == ST_IDLE) && !stop;
    assign sel_period = req_period[int'(sel)*PW +: PW];
    assign sel_dur    = req_dur[int'(sel)*DW +: DW];
    // Gated by rst_n so no source sees an acceptance that reset will discard.
    assign req_ready  = (grant_ok && rst_n) ? (NREQ'(1) << sel) : '0;
    assign busy       = (state != ST_IDLE);

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n   = state;
        ms_left_n = ms_left;
        period_n  = tone_period;
        gnt_n     = gnt_id;
        done_n    = '0;
        tone_en_n = tone_en;
        restart   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                tone_en_n = 1'b0;
                if (grant_ok) begin
                    period_n = sel_period;
                    gnt_n    = sel;
                    restart  = 1'b1;
                    if (sel_dur == '0) begin
                        // Zero-length note completes at once: no tone, no gap.
                        done_n[sel] = 1'b1;
                    end else begin
                        state_n   = ST_PLAY;
                        ms_left_n = sel_dur;
                        tone_en_n = (sel_period != '0);
                    end
                end
            end

            ST_PLAY: begin
                if (stop) begin
                    state_n   = ST_IDLE;
                    tone_en_n = 1'b0;
                end else if (tick) begin
                    if (ms_left == DW'(1)) begin
                        done_n[gnt_id] = 1'b1;
                        tone_en_n      = 1'b0;
                        if (GAP_MS == 0) begin
                            state_n = ST_IDLE;
                        end else begin
                            state_n   = ST_GAP;
                            ms_left_n = GAP_LEN;
                            restart   = 1'b1;
                        end
                    end else begin
                        ms_left_n = ms_left - 1'b1;
                    end
                end
            end

            ST_GAP: begin
                tone_en_n = 1'b0;
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (tick) begin
                    if (ms_left == DW'(1)) begin
                        state_n = ST_IDLE;
                    end else begin
                        ms_left_n = ms_left - 1'b1;
                    end
                end
            end

            default: begin
                state_n   = ST_IDLE;
                tone_en_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ms_left     <= '0;
            tone_period <= '0;
            gnt_id      <= '0;
            done        <= '0;
            tone_en     <= 1'b0;
        end else begin
            state       <= state_n;
            ms_left     <= ms_left_n;
            tone_period <= period_n;
            gnt_id      <= gnt_n;
            done        <= done_n;
            tone_en     <= tone_en_n;
        end
    end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// tb_buzzer_arbiter
//   Bench for buzzer_arbiter with TICK_DIV=10, GAP_MS=2, NREQ=3.
//   Expected done pulses are queued when a handshake is driven and matched by
//   a monitor; tone/busy/owner are checked cycle by cycle over each window.
module tb_buzzer_arbiter;

    localparam int NREQ = 3;
    localparam int PW   = 17;
    localparam int DW   = 8;
    localparam int TD   = 10;
    localparam int GAP  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                stop;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*PW-1:0]  req_period;
    logic [NREQ*DW-1:0]  req_dur;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     done;
    logic [PW-1:0]       tone_period;
    logic                tone_en;
    logic [1:0]          gnt_id;
    logic                busy;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        int         cyc;
        logic [2:0] mask;
    } exp_t;
    exp_t done_q[$];

    typedef struct {
        logic [2:0] valid;
        logic       stop;
        logic [2:0] ready;
    } vec_t;
    vec_t vecs[9];

    buzzer_arbiter #(
        .NREQ     (NREQ),
        .PW       (PW),
        .DW       (DW),
        .TICK_DIV (TD),
        .GAP_MS   (GAP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stop        (stop),
        .req_valid   (req_valid),
        .req_period  (req_period),
        .req_dur     (req_dur),
        .req_ready   (req_ready),
        .done        (done),
        .tone_period (tone_period),
        .tone_en     (tone_en),
        .gnt_id      (gnt_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic set_req(input int i, input int per, input int dur);
        req_period[i*PW +: PW] = PW'(per);
        req_dur[i*DW +: DW]    = DW'(dur);
    endtask

    task automatic push_done(input int at, input logic [2:0] mask);
        exp_t e;
        e.cyc  = at;
        e.mask = mask;
        done_q.push_back(e);
    endtask

    // Checks n consecutive cycles starting at the current sample point.
    task automatic span(input string nm, input int n, input logic en, input logic bsy,
                        input int per, input logic [1:0] g);
        for (int k = 0; k < n; k++) begin
            check({nm, "_tone_en"}, 32'(tone_en), 32'(en));
            check({nm, "_busy"}, 32'(busy), 32'(bsy));
            if (bsy) begin
                check({nm, "_period"}, 32'(tone_period), per);
                check({nm, "_gnt"}, 32'(gnt_id), 32'(g));
            end
            @(negedge clk);
        end
    endtask

    // Done-pulse scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done !== '0) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 0);
                end else begin
                    e = done_q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("done_mask", 32'(done), 32'(e.mask));
                end
            end else if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
                e = done_q.pop_front();
                check("done_missing", 32'(done), 32'(e.mask));
            end
        end
    end

    initial begin
        int n;

        vecs[0] = '{3'b001, 1'b0, 3'b001};
        vecs[1] = '{3'b010, 1'b0, 3'b010};
        vecs[2] = '{3'b100, 1'b0, 3'b100};
        vecs[3] = '{3'b011, 1'b0, 3'b001};
        vecs[4] = '{3'b110, 1'b0, 3'b010};
        vecs[5] = '{3'b101, 1'b0, 3'b001};
        vecs[6] = '{3'b111, 1'b0, 3'b001};
        vecs[7] = '{3'b111, 1'b1, 3'b000};
        vecs[8] = '{3'b000, 1'b0, 3'b000};

        rst_n      = 1'b0;
        stop       = 1'b0;
        req_valid  = '0;
        req_period = '0;
        req_dur    = '0;
        repeat (2) @(negedge clk);
        check("rst_tone_en", 32'(tone_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_period", 32'(tone_period), 0);
        check("rst_gnt", 32'(gnt_id), 0);
        check("rst_ready", 32'(req_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single note, full play + gap timing.
        set_req(0, 95602, 3);
        req_valid = 3'b001;
        #1;
        check("t1_ready", 32'(req_ready), 32'b001);
        n = cyc;
        push_done(n + 31, 3'b001);
        @(negedge clk);
        req_valid = '0;
        span("t1_play", 30, 1'b1, 1'b1, 95602, 2'd0);
        span("t1_gap", 20, 1'b0, 1'b1, 95602, 2'd0);
        check("t1_idle_busy", 32'(busy), 0);

        // 2: simultaneous req0/req2, req2 waits for the next IDLE.
        set_req(0, 95602, 3);
        set_req(2, 1234, 1);
        req_valid = 3'b101;
        #1;
        check("t2_ready", 32'(req_ready), 32'b001);
        n = cyc;
        push_done(n + 31, 3'b001);
        @(negedge clk);
        req_valid = 3'b100;
        #1;
        check("t2_ready_busy", 32'(req_ready), 0);
        span("t2_play0", 30, 1'b1, 1'b1, 95602, 2'd0);
        span("t2_gap0", 20, 1'b0, 1'b1, 95602, 2'd0);
        #1;
        check("t2_ready2", 32'(req_ready), 32'b100);
        push_done(cyc + 11, 3'b100);
        @(negedge clk);
        req_valid = '0;
        span("t2_play2", 10, 1'b1, 1'b1, 1234, 2'd2);
        span("t2_gap2", 20, 1'b0, 1'b1, 1234, 2'd2);
        check("t2_idle_busy", 32'(busy), 0);

        // 3: zero-duration note.
        set_req(1, 5000, 0);
        req_valid = 3'b010;
        #1;
        check("t3_ready", 32'(req_ready), 32'b010);
        push_done(cyc + 1, 3'b010);
        @(negedge clk);
        req_valid = '0;
        span("t3_idle", 3, 1'b0, 1'b0, 0, 2'd0);

        // 4: rest note (period 0).
        set_req(0, 0, 2);
        req_valid = 3'b001;
        #1;
        check("t4_ready", 32'(req_ready), 32'b001);
        push_done(cyc + 21, 3'b001);
        @(negedge clk);
        req_valid = '0;
        span("t4_play", 20, 1'b0, 1'b1, 0, 2'd0);
        span("t4_gap", 20, 1'b0, 1'b1, 0, 2'd0);
        check("t4_idle_busy", 32'(busy), 0);

        // 5: stop mid-note, held req1 served after stop falls.
        set_req(0, 95602, 3);
        set_req(1, 4000, 0);
        req_valid = 3'b001;
        #1;
        check("t5_ready", 32'(req_ready), 32'b001);
        @(negedge clk);
        req_valid = 3'b010;
        span("t5_play", 11, 1'b1, 1'b1, 95602, 2'd0);
        check("t5_pre_stop_en", 32'(tone_en), 1);
        stop = 1'b1;
        @(negedge clk);
        check("t5_stop_en", 32'(tone_en), 0);
        check("t5_stop_busy", 32'(busy), 0);
        #1;
        check("t5_stop_blocks", 32'(req_ready), 0);
        stop = 1'b0;
        #1;
        check("t5_ready1", 32'(req_ready), 32'b010);
        push_done(cyc + 1, 3'b010);
        @(negedge clk);
        req_valid = '0;
        span("t5_idle", 3, 1'b0, 1'b0, 0, 2'd0);

        // 6: reset mid-PLAY, then a full note.
        set_req(0, 95602, 3);
        req_valid = 3'b001;
        #1;
        check("t6_ready", 32'(req_ready), 32'b001);
        @(negedge clk);
        req_valid = '0;
        span("t6_play", 14, 1'b1, 1'b1, 95602, 2'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_en", 32'(tone_en), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_period", 32'(tone_period), 0);
        check("t6_rst_gnt", 32'(gnt_id), 0);
        check("t6_rst_done", 32'(done), 0);
        set_req(0, 777, 1);
        req_valid = 3'b001;
        #1;
        check("t6_rst_ready", 32'(req_ready), 0);
        rst_n = 1'b1;
        #1;
        check("t6_ready_new", 32'(req_ready), 32'b001);
        push_done(cyc + 11, 3'b001);
        @(negedge clk);
        req_valid = '0;
        span("t6_play_new", 10, 1'b1, 1'b1, 777, 2'd0);
        span("t6_gap_new", 20, 1'b0, 1'b1, 777, 2'd0);
        check("t6_idle_busy", 32'(busy), 0);

        // Priority / stop table in IDLE, all notes zero-length.
        req_dur = '0;
        foreach (vecs[i]) begin
            req_valid = vecs[i].valid;
            stop      = vecs[i].stop;
            #1;
            check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].ready));
            check($sformatf("vec%0d_busy", i), 32'(busy), 0);
            if (vecs[i].ready != 3'b000) push_done(cyc + 1, vecs[i].ready);
            @(negedge clk);
        end
        req_valid = '0;
        stop      = 1'b0;
        repeat (3) @(negedge clk);
        check("done_queue_empty", 32'(done_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
